mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths fixed for RV32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  EX/MEM entry valid; inputs below held stable while mem_stall=1.
REQ-005 ex_alu_result  in  32  byte address for loads/stores, result for ALU ops.
REQ-006 ex_store_data  in  32  unaligned store source (rs2).
REQ-007 ex_pc_plus_4  in  32  link value for JAL/JALR.
REQ-008 exmem_rd  in  5; exmem_is_load  in  1; exmem_is_store  in  1; exmem_reg_write  in  1; exmem_mem_to_reg  in  2; exmem_funct3  in  3.
REQ-009 mem_stall  out  1  upstream hold request.
REQ-010 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (word-aligned, [1:0]=0); dmem_wdata  out  32; dmem_be  out  4.
REQ-011 dmem_gnt  in  1  request accepted; dmem_rvalid  in  1; dmem_rdata  in  32.
REQ-012 wb_valid  out  1; wb_rd  out  5; wb_reg_write  out  1; wb_data  out  32; mem_misalign  out  1 (all registered).

Function
REQ-013 FSM states IDLE, ADDR (request pending grant), DATA (load awaiting rvalid).
REQ-014 mem_op = in_valid & (exmem_is_load | exmem_is_store); dmem_req = 1 in IDLE with mem_op, and in ADDR; dmem_we = exmem_is_store.
REQ-015 IDLE/ADDR with dmem_req & dmem_gnt: store -> IDLE (complete this cycle); load -> DATA. No grant -> ADDR.
REQ-016 DATA & dmem_rvalid -> IDLE, load complete this cycle; dmem_req = 0 in DATA.
REQ-017 Non-memory valid entry completes in the cycle presented, no memory access.
REQ-018 mem_stall = mem_op & ~complete (combinational); 0 when in_valid=0.
REQ-019 On completion edge: wb_valid=1, wb_rd, wb_reg_write loaded; otherwise wb_valid=0, wb_reg_write=0.
REQ-020 wb_data select: mem_to_reg 00 ALU result, 01 aligned load data, 10 pc+4, 11 ALU result.
REQ-021 Minimum latency: ALU/store/load-with-same-cycle-gnt-and-next-cycle-rvalid = 1 / 1 / 2 cycles to wb_valid.
REQ-022 Store lanes: SB (000) wdata = byte replicated x4, be = 0001<<addr[1:0]; SH (001) halfword replicated x2, be = 0011<<{addr[1],1'b0}; SW (010) be = 1111.
REQ-023 Load extract from dmem_rdata by captured addr[1:0]: LB/LH sign-extend, LBU(100)/LHU(101) zero-extend, LW raw.
REQ-024 Address and funct3 captured into registers on grant; DATA-state extraction uses captured values.
REQ-025 dmem_rvalid outside DATA, and dmem_gnt while dmem_req=0, ignored.

Reset
REQ-026 rst asserted: state=IDLE, wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, mem_misalign=0, captured regs=0, immediately and asynchronously.
REQ-027 Reset mid-transaction abandons it; dmem_req drops while rst=1; later rvalid ignored.

Configuration
REQ-028 Macro MEM_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 issues no dmem_req, completes in one cycle with wb_valid=1, wb_reg_write=0, mem_misalign=1 for one cycle.
REQ-029 Macro undefined: address low bits forced to natural alignment (half: [0]=0, word: [1:0]=0); mem_misalign tied 0.

Structure
REQ-030 Shared package rv32_pkg: mem_to_reg encodings, load/store funct3 codes, FSM state encoding.
REQ-031 One combinational sub-module load_align: rdata, addr[1:0], funct3 -> 32-bit extended load value.

Verification
REQ-032 ALU op, mem_to_reg=00, result 0x1234_5678, rd=5 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234_5678, mem_stall never high.
REQ-033 SB addr 0x103, data 0xAB, gnt same cycle -> dmem_addr=0x100, be=1000, wdata=0xABABABAB, stall 0, wb_reg_write=0.
REQ-034 LB addr 0x201, gnt delayed 2 cycles, rvalid 3 cycles later, rdata 0x0000_8000 -> stall held 5 cycles, wb_data=0xFFFF_FF80.
REQ-035 LHU addr 0x302, rdata 0xBEEF_0000 -> wb_data=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-036 rst asserted in DATA, rvalid after release -> no wb_valid, state IDLE, dmem_req 0.
REQ-037 With MEM_MISALIGN_TRAP_EN, LW addr 0x402 -> no dmem_req, mem_misalign=1 one cycle, wb_reg_write=0; without, dmem_addr=0x400 and load proceeds.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the memory stage: write-back source encodings,
// load/store funct3 codes, memory FSM state encoding and an alignment helper.
package rv32_pkg;

  // Write-back source select carried down the pipe from decode
  typedef enum logic [1:0] {
    M2R_ALU  = 2'b00,
    M2R_LOAD = 2'b01,
    M2R_PC4  = 2'b10,
    M2R_ALT  = 2'b11
  } mem_to_reg_e;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Data-memory handshake FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // waiting for a memory op
    ST_ADDR = 2'b01,  // request raised, grant not yet seen
    ST_DATA = 2'b10   // load accepted, waiting for read data
  } mem_state_e;

  // Forces the low address bits to the natural alignment of the access size.
  // funct3[1:0] gives the size for both loads and stores.
  function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                             input logic [2:0]  funct3);
    logic [31:0] res;
    res = addr;
    case (funct3[1:0])
      2'b01:   res[0]   = 1'b0;
      2'b10:   res[1:0] = 2'b00;
      default: res      = addr;
    endcase
    return res;
  endfunction

  // True when an access of the given size does not sit on its natural boundary
  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [2:0] funct3);
    logic res;
    case (funct3[1:0])
      2'b01:   res = addr_lo[0];
      2'b10:   res = (addr_lo != 2'b00);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: selects the addressed byte/halfword from the
// returned memory word and sign- or zero-extends it according to funct3.
module load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lanes, then extend by access type
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path through the case statements can leave a latch behind.
    byte_sel  = 8'h00;
    half_sel  = 16'h0000;
    load_data = rdata;

    case (addr_lo)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data = {24'h000000, byte_sel};
      F3_LHU:  load_data = {16'h0000, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM pipeline stage: issues loads/stores over a req/gnt/rvalid data
// memory port, stalls upstream until the access completes, and registers the
// write-back result.
// Build option: define MEM_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses (no memory request, mem_misalign pulse) instead of silently
// forcing the address to natural alignment.
module mem_stage
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        in_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_pc_plus_4,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_is_load,
  input  logic        exmem_is_store,
  input  logic        exmem_reg_write,
  input  logic [1:0]  exmem_mem_to_reg,
  input  logic [2:0]  exmem_funct3,

  output logic        mem_stall,

  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,

  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        mem_misalign
);

  mem_state_e  state;
  logic [1:0]  addr_lo_q;   // captured byte offset for load extraction
  logic [2:0]  funct3_q;    // captured access type for load extraction

  logic        mem_op;
  logic        misaligned;
  logic [31:0] eff_addr;
  logic        accept;
  logic        complete;
  logic [31:0] load_data;
  logic [31:0] wb_sel;

  assign mem_op = in_valid & (exmem_is_load | exmem_is_store);

`ifdef MEM_MISALIGN_TRAP_EN
  // Misaligned half/word accesses are trapped only when first presented
  assign misaligned = mem_op & (state == ST_IDLE) &
                      is_misaligned(ex_alu_result[1:0], exmem_funct3);
  assign eff_addr   = ex_alu_result;
`else
  assign misaligned = 1'b0;
  assign eff_addr   = align_addr(ex_alu_result, exmem_funct3);
`endif

  // Request is live on first presentation and held while waiting for grant;
  // reset forces it low so an abandoned access never reaches memory.
  always_comb begin
    dmem_req = 1'b0;
    case (state)
      ST_IDLE: dmem_req = mem_op & ~misaligned;
      ST_ADDR: dmem_req = 1'b1;
      default: dmem_req = 1'b0;
    endcase
    if (rst) dmem_req = 1'b0;
  end

  assign dmem_we   = exmem_is_store;
  assign dmem_addr = {eff_addr[31:2], 2'b00};
  assign accept    = dmem_req & dmem_gnt;

  // Store lane steering: replicate the source and enable the addressed bytes
  always_comb begin
    dmem_wdata = ex_store_data;
    dmem_be    = 4'b1111;
    case (exmem_funct3)
      F3_SB: begin
        dmem_wdata = {4{ex_store_data[7:0]}};
        dmem_be    = 4'b0001 << eff_addr[1:0];
      end
      F3_SH: begin
        dmem_wdata = {2{ex_store_data[15:0]}};
        dmem_be    = 4'b0011 << {eff_addr[1], 1'b0};
      end
      default: begin
        dmem_wdata = ex_store_data;
        dmem_be    = 4'b1111;
      end
    endcase
  end

  // Decide whether the entry in the stage retires on this clock edge
  always_comb begin
    complete = 1'b0;
    case (state)
      ST_IDLE: complete = in_valid &
                          (~mem_op | misaligned | (accept & exmem_is_store));
      ST_ADDR: complete = accept & exmem_is_store;
      ST_DATA: complete = dmem_rvalid;
      default: complete = 1'b0;
    endcase
  end

  assign mem_stall = mem_op & ~complete;

  // Loads are always extracted with the offset/type captured at grant time
  load_align u_load_align (
    .rdata     (dmem_rdata),
    .addr_lo   (addr_lo_q),
    .funct3    (funct3_q),
    .load_data (load_data)
  );

  // Write-back source select
  always_comb begin
    wb_sel = ex_alu_result;
    case (mem_to_reg_e'(exmem_mem_to_reg))
      M2R_LOAD: wb_sel = load_data;
      M2R_PC4:  wb_sel = ex_pc_plus_4;
      default:  wb_sel = ex_alu_result;
    endcase
  end

  // Handshake FSM with registered write-back outputs and grant-time capture
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (rst) begin
      state        <= ST_IDLE;
      addr_lo_q    <= 2'b00;
      funct3_q     <= 3'b000;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      wb_data      <= 32'h0000_0000;
      mem_misalign <= 1'b0;
    end else begin
      wb_valid     <= complete;
      wb_reg_write <= complete & exmem_reg_write & ~misaligned;
      mem_misalign <= complete & misaligned;

      if (complete) begin
        wb_rd   <= exmem_rd;
        wb_data <= wb_sel;
      end

      if (accept) begin
        addr_lo_q <= eff_addr[1:0];
        funct3_q  <= exmem_funct3;
      end

      case (state)
        ST_IDLE, ST_ADDR: begin
          if (accept) begin
            state <= exmem_is_store ? ST_IDLE : ST_DATA;
          end else if (dmem_req) begin
            state <= ST_ADDR;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (dmem_rvalid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU/link write-back, store lane steering,
// loads with grant/rvalid latency, extension modes, reset abandonment and the
// misalignment build option.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc_plus_4;
  logic [4:0]  exmem_rd;
  logic        exmem_is_load;
  logic        exmem_is_store;
  logic        exmem_reg_write;
  logic [1:0]  exmem_mem_to_reg;
  logic [2:0]  exmem_funct3;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        mem_misalign;

  int passed = 0;
  int total  = 0;
  int stall_cycles;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .ex_alu_result    (ex_alu_result),
    .ex_store_data    (ex_store_data),
    .ex_pc_plus_4     (ex_pc_plus_4),
    .exmem_rd         (exmem_rd),
    .exmem_is_load    (exmem_is_load),
    .exmem_is_store   (exmem_is_store),
    .exmem_reg_write  (exmem_reg_write),
    .exmem_mem_to_reg (exmem_mem_to_reg),
    .exmem_funct3     (exmem_funct3),
    .mem_stall        (mem_stall),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_be          (dmem_be),
    .dmem_gnt         (dmem_gnt),
    .dmem_rvalid      (dmem_rvalid),
    .dmem_rdata       (dmem_rdata),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_reg_write     (wb_reg_write),
    .wb_data          (wb_data),
    .mem_misalign     (mem_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (observed running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    in_valid         = 1'b0;
    ex_alu_result    = 32'h0;
    ex_store_data    = 32'h0;
    ex_pc_plus_4     = 32'h0;
    exmem_rd         = 5'd0;
    exmem_is_load    = 1'b0;
    exmem_is_store   = 1'b0;
    exmem_reg_write  = 1'b0;
    exmem_mem_to_reg = 2'b00;
    exmem_funct3     = 3'b000;
    dmem_gnt         = 1'b0;
    dmem_rvalid      = 1'b0;
    dmem_rdata       = 32'h0;
  endtask

  task automatic drive(input logic ld, input logic st, input logic rw,
                       input logic [1:0] m2r, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] pc4);
    in_valid         = 1'b1;
    exmem_is_load    = ld;
    exmem_is_store   = st;
    exmem_reg_write  = rw;
    exmem_mem_to_reg = m2r;
    exmem_funct3     = f3;
    exmem_rd         = rd;
    ex_alu_result    = alu;
    ex_store_data    = sd;
    ex_pc_plus_4     = pc4;
  endtask

  // Load with same-cycle grant and next-cycle rvalid: result two edges later
  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] exp);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 2'b01, f3, 5'd9, addr, 32'h0, 32'h0);
    dmem_gnt = 1'b1;
    #1 check({tag, " stall_req"}, {31'h0, mem_stall}, 32'h1);
    @(negedge clk);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1 check({tag, " stall_done"}, {31'h0, mem_stall}, 32'h0);
    @(posedge clk);
    #1;
    check({tag, " wb_valid"}, {31'h0, wb_valid}, 32'h1);
    check({tag, " wb_data"}, wb_data, exp);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset state
    #2;
    check("rst wb_valid", {31'h0, wb_valid}, 32'h0);
    check("rst wb_reg_write", {31'h0, wb_reg_write}, 32'h0);
    check("rst wb_rd", {27'h0, wb_rd}, 32'h0);
    check("rst wb_data", wb_data, 32'h0);
    check("rst mem_misalign", {31'h0, mem_misalign}, 32'h0);
    check("rst dmem_req", {31'h0, dmem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ALU op completes in one cycle, never stalls
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 5'd5, 32'h1234_5678, 32'h0, 32'h0);
    #1;
    check("alu stall", {31'h0, mem_stall}, 32'h0);
    check("alu dmem_req", {31'h0, dmem_req}, 32'h0);
    @(posedge clk);
    #1;
    check("alu wb_valid", {31'h0, wb_valid}, 32'h1);
    check("alu wb_rd", {27'h0, wb_rd}, 32'd5);
    check("alu wb_data", wb_data, 32'h1234_5678);
    check("alu wb_reg_write", {31'h0, wb_reg_write}, 32'h1);
    clear_inputs();
    @(posedge clk);
    #1 check("idle wb_valid", {31'h0, wb_valid}, 32'h0);

    // JAL link value selected by mem_to_reg=10
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 5'd1, 32'h0000_0099, 32'h0, 32'h0000_0088);
    @(posedge clk);
    #1 check("jal wb_data", wb_data, 32'h0000_0088);
    clear_inputs();

    // SB at 0x103 with same-cycle grant
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0000_0103, 32'h0000_00AB, 32'h0);
    dmem_gnt = 1'b1;
    #1;
    check("sb dmem_req", {31'h0, dmem_req}, 32'h1);
    check("sb dmem_we", {31'h0, dmem_we}, 32'h1);
    check("sb dmem_addr", dmem_addr, 32'h0000_0100);
    check("sb dmem_be", {28'h0, dmem_be}, 32'h8);
    check("sb dmem_wdata", dmem_wdata, 32'hABAB_ABAB);
    check("sb stall", {31'h0, mem_stall}, 32'h0);
    @(posedge clk);
    #1;
    check("sb wb_valid", {31'h0, wb_valid}, 32'h1);
    check("sb wb_reg_write", {31'h0, wb_reg_write}, 32'h0);
    clear_inputs();

    // SH at 0x102: upper halfword lanes
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 5'd0, 32'h0000_0102, 32'h1234_CDEF, 32'h0);
    dmem_gnt = 1'b1;
    #1;
    check("sh dmem_be", {28'h0, dmem_be}, 32'hC);
    check("sh dmem_wdata", dmem_wdata, 32'hCDEF_CDEF);
    @(posedge clk);
    #1 clear_inputs();

    // SW at 0x104: full word
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 5'd0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0);
    dmem_gnt = 1'b1;
    #1;
    check("sw dmem_be", {28'h0, dmem_be}, 32'hF);
    check("sw dmem_wdata", dmem_wdata, 32'hDEAD_BEEF);
    check("sw dmem_addr", dmem_addr, 32'h0000_0104);
    @(posedge clk);
    #1 clear_inputs();

    // LB at 0x201: grant on the third cycle, rvalid three cycles after grant;
    // a stray grant while in DATA must be ignored
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 5'd7, 32'h0000_0201, 32'h0, 32'h0);
    stall_cycles = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      dmem_gnt    = (c == 2) || (c == 3);
      dmem_rvalid = (c == 5);
      dmem_rdata  = (c == 5) ? 32'h0000_8000 : 32'hFFFF_FFFF;
      #1;
      if (mem_stall) stall_cycles++;
      if (c == 0) check("lb dmem_addr", dmem_addr, 32'h0000_0200);
      if (c == 3) check("lb req in data", {31'h0, dmem_req}, 32'h0);
    end
    check("lb stall cycles", stall_cycles, 32'd5);
    @(posedge clk);
    #1;
    check("lb wb_valid", {31'h0, wb_valid}, 32'h1);
    check("lb wb_rd", {27'h0, wb_rd}, 32'd7);
    check("lb wb_data", wb_data, 32'hFFFF_FF80);
    clear_inputs();

    // Extension modes with minimum load latency
    do_load("lhu", 3'b101, 32'h0000_0302, 32'hBEEF_0000, 32'h0000_BEEF);
    do_load("lh",  3'b001, 32'h0000_0302, 32'hBEEF_0000, 32'hFFFF_BEEF);
    do_load("lbu", 3'b100, 32'h0000_0203, 32'h8000_0000, 32'h0000_0080);
    do_load("lw",  3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // rvalid while idle is ignored
    @(negedge clk);
    dmem_rvalid = 1'b1;
    @(posedge clk);
    #1 check("stray rvalid wb_valid", {31'h0, wb_valid}, 32'h0);
    clear_inputs();

    // Reset while waiting for grant drops the request immediately
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 5'd3, 32'h0000_0500, 32'h0, 32'h0);
    @(negedge clk);
    #1 check("addr dmem_req", {31'h0, dmem_req}, 32'h1);
    rst = 1'b1;
    #1 check("rst addr dmem_req", {31'h0, dmem_req}, 32'h0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;

    // Reset in DATA abandons the load; late rvalid is ignored
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 5'd3, 32'h0000_0600, 32'h0, 32'h0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst data wb_valid", {31'h0, wb_valid}, 32'h0);
    check("rst data dmem_req", {31'h0, dmem_req}, 32'h0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_5555;
    #1 check("post rst dmem_req", {31'h0, dmem_req}, 32'h0);
    @(posedge clk);
    #1 check("post rst wb_valid", {31'h0, wb_valid}, 32'h0);
    clear_inputs();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 5'd4, 32'h0000_0042, 32'h0, 32'h0);
    #1 check("post rst alu stall", {31'h0, mem_stall}, 32'h0);
    @(posedge clk);
    #1 check("post rst alu wb_data", wb_data, 32'h0000_0042);
    clear_inputs();

    // Misaligned LW at 0x402
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 5'd6, 32'h0000_0402, 32'h0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    check("mis dmem_req", {31'h0, dmem_req}, 32'h0);
    check("mis stall", {31'h0, mem_stall}, 32'h0);
    @(posedge clk);
    #1;
    check("mis wb_valid", {31'h0, wb_valid}, 32'h1);
    check("mis wb_reg_write", {31'h0, wb_reg_write}, 32'h0);
    check("mis mem_misalign", {31'h0, mem_misalign}, 32'h1);
    clear_inputs();
    @(posedge clk);
    #1 check("mis pulse end", {31'h0, mem_misalign}, 32'h0);
`else
    dmem_gnt = 1'b1;
    #1;
    check("mis dmem_req", {31'h0, dmem_req}, 32'h1);
    check("mis dmem_addr", dmem_addr, 32'h0000_0400);
    @(negedge clk);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1122_3344;
    @(posedge clk);
    #1;
    check("mis wb_data", wb_data, 32'h1122_3344);
    check("mis mem_misalign", {31'h0, mem_misalign}, 32'h0);
    clear_inputs();
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
